// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package pc_fetch_ctrl_pkg;

    localparam int unsigned PC_WIDTH = 16;
    localparam int unsigned CNT_W    = 8;
    localparam logic [PC_WIDTH-1:0] RESET_VEC = 16'h0000;

    typedef enum logic [2:0] {
        ST_CLR    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_FETCH  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    typedef struct packed {
        logic re;
        logic incre;
        logic sel;
        logic cs;
        logic w;
        logic r;
    } pc_ctrl_t;

    // States in which the sequencer is actively working on an instruction.
    function automatic logic is_busy(input state_e s);
        return (s == ST_CLR) || (s == ST_FETCH) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_timeout_ctr.sv
// Counts consecutive unanswered fetch requests; flags the last allowed one.
module fetch_timeout_ctr
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // tc marks the miss that exhausts the budget; the caller acts on it.
    assign tc_o = (cnt_q == CNT_W'(MAX_WAIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives PC control pins, requests instruction words and
// hands them to decode over a valid/ack handshake.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = PC_WIDTH,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             clk_i,
    input  logic             re_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             halt_i,
    input  logic             jmp_valid_i,
    input  logic [WIDTH-1:0] jmp_addr_i,
    input  logic [WIDTH-1:0] pc_in_i,
    output logic             pc_re_o,
    output logic             pc_incre_o,
    output logic             pc_sel_o,
    output logic             pc_cs_o,
    output logic             pc_w_o,
    output logic             pc_r_o,
    output logic [WIDTH-1:0] pc_load_o,
    output logic             mem_req_o,
    output logic [WIDTH-1:0] mem_addr_o,
    input  logic             mem_ready_i,
    input  logic [WIDTH-1:0] mem_data_i,
    output logic [WIDTH-1:0] instr_o,
    output logic             instr_valid_o,
    input  logic             instr_ack_i,
    output logic             busy_o,
    output logic             timeout_o
);

    state_e           state_q;
    logic [WIDTH-1:0] instr_q;
    logic             instr_valid_q;
    logic             timeout_q;

    logic     req_c;
    logic     hit_c;
    logic     miss_c;
    logic     tc_c;
    pc_ctrl_t pc_ctrl;

    // Stall only masks the request; mem_ready without a request is ignored.
    assign req_c  = !re_i && (state_q == ST_FETCH) && !stall_i;
    assign hit_c  = req_c && mem_ready_i;
    assign miss_c = req_c && !mem_ready_i;

    fetch_timeout_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timeout (
        .clk_i (clk_i),
        .rst_i (re_i),
        .en_i  (miss_c),
        .clr_i (hit_c),
        .tc_o  (tc_c)
    );

    always_ff @(posedge clk_i or posedge re_i) begin
        if (re_i) begin
            state_q       <= ST_CLR;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_CLR: state_q <= ST_IDLE;
                ST_IDLE: begin
                    if (start_i) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (hit_c) begin
                        instr_q       <= mem_data_i;
                        instr_valid_q <= 1'b1;
                        state_q       <= ST_HOLD;
                    end else if (miss_c && tc_c) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_ERR;
                    end
                end
                ST_HOLD: begin
                    if (instr_ack_i) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= halt_i ? ST_HALTED : ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    if (start_i) state_q <= ST_FETCH;
                end
                ST_ERR: state_q <= ST_ERR;
                default: state_q <= ST_CLR;
            endcase
        end
    end

    // PC pins decode from state; the PC commit happens in the ack cycle itself.
    always_comb begin
        pc_ctrl   = '0;
        pc_load_o = '0;
        mem_req_o = 1'b0;
        busy_o    = 1'b0;
        if (!re_i) begin
            pc_ctrl.cs = 1'b1;
            pc_ctrl.r  = 1'b1;
            mem_req_o  = req_c;
            busy_o     = is_busy(state_q);
            case (state_q)
                ST_CLR: begin
                    pc_ctrl.re = 1'b1;
                    pc_ctrl.w  = 1'b1;
                    pc_load_o  = WIDTH'(RESET_VEC);
                end
                ST_HOLD: begin
                    if (instr_ack_i) begin
                        pc_ctrl.w = 1'b1;
                        if (jmp_valid_i) begin
                            pc_ctrl.sel = 1'b1;
                            pc_load_o   = jmp_addr_i;
                        end else begin
                            pc_ctrl.incre = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_re_o       = pc_ctrl.re;
    assign pc_incre_o    = pc_ctrl.incre;
    assign pc_sel_o      = pc_ctrl.sel;
    assign pc_cs_o       = pc_ctrl.cs;
    assign pc_w_o        = pc_ctrl.w;
    assign pc_r_o        = pc_ctrl.r;
    assign mem_addr_o    = re_i ? '0 : pc_in_i;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign timeout_o     = timeout_q;

endmodule
